crc5_rr_sched: RTL

Round-robin scheduler that shares one pipelined CRC-5 engine (16-bit word in, 5-bit CRC out, fixed latency) between NREQ requesters. It arbitrates word requests, drives the engine input, tracks in-flight words with a tag pipeline, and returns each CRC through a per-requester response FIFO. Per-requester credits guarantee the FIFOs never overflow, so the engine never stalls.

---
 rtl/crc5_rr_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/crc5_rr_sched.sv
// crc5_rr_sched
//
// Shares one pipelined CRC engine between NREQ requesters. Requests are
// granted round-robin, one word per cycle. The granted word goes out
// registered on eng_m/eng_issue. A tag pipeline follows each word through
// the engine's fixed latency, so every returning CRC is written into the
// response FIFO of the requester that sent the word.
//
// Each requester holds a credit count equal to its in-flight words plus its
// FIFO occupancy. A requester is granted only while that count is below
// DEPTH. Because of this, a FIFO can never overflow and the engine never
// has to stall.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   req_valid  per-requester word available
//   req_data   per-requester word, slice [i*W +: W]
//   req_ready  one-hot grant (combinational), transfer on valid & ready
//   eng_m      registered word presented to the CRC engine
//   eng_issue  registered, eng_m carries a live word this cycle
//   eng_crc    engine result, LAT cycles after the matching eng_m
//   rsp_valid  per-requester response FIFO non-empty
//   rsp_crc    per-requester FIFO head, slice [i*CW +: CW]
//   rsp_ready  per-requester pop request

module crc5_rr_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int CW    = 5,
  parameter int LAT   = 3,
  parameter int DEPTH = LAT + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [W-1:0]         eng_m,
  output logic                 eng_issue,
  input  logic [CW-1:0]        eng_crc,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*CW-1:0]   rsp_crc,
  input  logic [NREQ-1:0]      rsp_ready
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1  = PW + 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   issue_id;
  logic [PW-1:0]   grant_id;
  logic            grant_any;
  logic [PW:0]     rot;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] wr_en;

  logic            tag_v  [LAT];
  logic [PW-1:0]   tag_id [LAT];

  logic [CW-1:0]   mem         [NREQ][DEPTH];
  logic [AW-1:0]   wr_ptr      [NREQ];
  logic [AW-1:0]   rd_ptr      [NREQ];
  logic [CNTW-1:0] fifo_cnt    [NREQ];
  logic [CNTW-1:0] outstanding [NREQ];

  // The credit check uses the registered count only, so a pop in the same
  // cycle cannot free the slot early. This keeps the grant path short.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (outstanding[i] < CNTW'(DEPTH));
    end
  end

  // Rotating search starting at ptr. The index wraps by subtraction, which
  // also handles NREQ values that are not a power of two. Grants are
  // suppressed during reset so that no credit is taken while state clears.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    rot       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot = {1'b0, ptr} + PW1'(k);
      if (rot >= PW1'(NREQ)) begin
        rot = rot - PW1'(NREQ);
      end
      cand = rot[PW-1:0];
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    grant_any = grant_any && !rst;
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      eng_m     <= '0;
      eng_issue <= 1'b0;
      issue_id  <= '0;
    end else begin
      eng_issue <= grant_any;
      eng_m     <= grant_any ? req_data[int'(grant_id)*W +: W] : '0;
      issue_id  <= grant_id;
      if (grant_any) begin
        ptr <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
      end
    end
  end

  // Stage 0 follows the word on eng_m. The last stage lines up with the
  // cycle where eng_crc carries that word's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= eng_issue;
      tag_id[0] <= issue_id;
      for (int s = 1; s < LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    wr_en = '0;
    pop   = '0;
    for (int i = 0; i < NREQ; i++) begin
      wr_en[i] = tag_v[LAT-1] && (tag_id[LAT-1] == PW'(i));
      pop[i]   = rsp_valid[i] && rsp_ready[i];
    end
  end

  // Credits: a grant and a pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !pop[i]) begin
          outstanding[i] <= outstanding[i] + CNTW'(1);
        end else if (!req_ready[i] && pop[i]) begin
          outstanding[i] <= outstanding[i] - CNTW'(1);
        end
      end
    end
  end

  // Storage has no reset. The head is masked by occupancy, so stale entries
  // are never visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= eng_crc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        fifo_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (wr_en[i]) begin
          wr_ptr[i] <= (wr_ptr[i] == AW'(DEPTH - 1)) ? '0 : wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= (rd_ptr[i] == AW'(DEPTH - 1)) ? '0 : rd_ptr[i] + AW'(1);
        end
        if (wr_en[i] && !pop[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] + CNTW'(1);
        end else if (!wr_en[i] && pop[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] - CNTW'(1);
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_crc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (fifo_cnt[i] != '0);
      if (fifo_cnt[i] != '0) begin
        rsp_crc[i*CW +: CW] = mem[i][rd_ptr[i]];
      end
    end
  end

endmodule
